// File: rtl/vip_pkg.sv
// Shared definitions for the video-input-path blocks: FSM encoding and image defaults.
package vip_pkg;

  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 480;
  localparam int CW_DEF    = 11;
  localparam int RW_DEF    = 10;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_VS   = 3'd1,
    ST_WAIT_LINE = 3'd2,
    ST_LINE      = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  // True while a frame is being received (lines are expected).
  function automatic logic in_frame(input state_t st);
    return (st == ST_WAIT_LINE) || (st == ST_LINE);
  endfunction

endpackage

// File: rtl/vip_edge_detect.sv
// Registered level and rise/fall pulses of a sync input; the first sample after
// reset never produces an edge, so a level held through reset is ignored.
module vip_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic level_r;
  logic armed_r;
  logic rise_r;
  logic fall_r;

  // Sample the input and compare against the previous sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_r <= 1'b0;
      armed_r <= 1'b0;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
    end else begin
      level_r <= din;
      armed_r <= 1'b1;
      rise_r  <= armed_r & din & ~level_r;
      fall_r  <= armed_r & ~din & level_r;
    end
  end

  assign level = level_r;
  assign rise  = rise_r;
  assign fall  = fall_r;

endmodule

// File: rtl/matrix_window_ctrl.sv
// Tracks frame/line position of the 3x3 matrix generator output and flags
// windows that lie fully inside the image.
module matrix_window_ctrl
  import vip_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int CW    = CW_DEF,
  parameter int RW    = RW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          mat_vsync,
  input  logic          mat_href,
  input  logic          mat_clken,
  output logic          win_valid,
  output logic [CW-1:0] col_idx,
  output logic [RW-1:0] row_idx,
  output logic          frame_start,
  output logic          frame_done,
  output logic          line_err,
  output logic          frame_err,
  output logic          busy
);

  localparam logic [CW-1:0] COL_END = CW'(IMG_W);
  localparam logic [RW-1:0] ROW_END = RW'(IMG_H);
  localparam logic [CW-1:0] COL_MIN = CW'(2);
  localparam logic [RW-1:0] ROW_MIN = RW'(2);

  state_t        state_r, state_n;
  logic [CW-1:0] col_cnt_r;
  logic [RW-1:0] row_cnt_r;
  logic [RW-1:0] row_next_s;
  logic          vs_lvl_s, vs_rise_s, vs_fall_s;
  logic          hr_lvl_s, hr_rise_s, hr_fall_s;
  logic          unused_vs_s;
  logic          in_line_s, pix_s, win_s;
  logic          early_s, start_s, line_end_s, stray_s;
  logic          frame_done_s, busy_s;
  logic          win_valid_r, frame_start_r, frame_done_r, busy_r;
  logic          line_err_r, frame_err_r;
  logic [CW-1:0] col_idx_r;
  logic [RW-1:0] row_idx_r;

  vip_edge_detect u_vs_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (mat_vsync),
    .level(vs_lvl_s),
    .rise (vs_rise_s),
    .fall (vs_fall_s)
  );

  vip_edge_detect u_hr_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (mat_href),
    .level(hr_lvl_s),
    .rise (hr_rise_s),
    .fall (hr_fall_s)
  );

  assign unused_vs_s = vs_lvl_s | vs_fall_s;

  // The href edge pulse lags the raw input, so the first two pixels of a line
  // are accepted in WAIT_LINE; a line still high after an early vsync is ignored.
  assign in_line_s  = (state_r == ST_LINE) ||
                      ((state_r == ST_WAIT_LINE) && (hr_rise_s || !hr_lvl_s));
  assign pix_s      = mat_href & mat_clken & in_line_s;
  assign win_s      = pix_s && (col_cnt_r >= COL_MIN) && (row_cnt_r >= ROW_MIN) &&
                      (row_cnt_r < ROW_END);
  assign row_next_s = row_cnt_r + RW'(1);
  assign early_s    = vs_rise_s && in_frame(state_r);
  assign start_s    = ((state_r == ST_WAIT_VS) && en && vs_rise_s) || early_s;
  assign line_end_s = (state_r == ST_LINE) && hr_fall_s && !vs_rise_s;
  assign stray_s    = hr_rise_s && !in_frame(state_r) && (row_cnt_r == ROW_END);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state logic; vsync takes priority over an href fall in the same cycle.
  always_comb begin
    state_n = state_r;
    case (state_r)
      ST_IDLE:      state_n = en ? ST_WAIT_VS : ST_IDLE;
      ST_WAIT_VS: begin
        if (!en)            state_n = ST_IDLE;
        else if (vs_rise_s) state_n = ST_WAIT_LINE;
        else                state_n = ST_WAIT_VS;
      end
      ST_WAIT_LINE: begin
        if (vs_rise_s)      state_n = ST_WAIT_LINE;
        else if (hr_rise_s) state_n = ST_LINE;
        else                state_n = ST_WAIT_LINE;
      end
      ST_LINE: begin
        if (vs_rise_s)      state_n = ST_WAIT_LINE;
        else if (hr_fall_s) state_n = (row_next_s == ROW_END) ? ST_DONE : ST_WAIT_LINE;
        else                state_n = ST_LINE;
      end
      ST_DONE:      state_n = ST_WAIT_VS;
      default:      state_n = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state.
  always_comb begin
    frame_done_s = 1'b0;
    busy_s       = 1'b0;
    case (state_n)
      ST_DONE: begin
        frame_done_s = 1'b1;
        busy_s       = 1'b1;
      end
      ST_WAIT_LINE, ST_LINE: busy_s = 1'b1;
      ST_IDLE, ST_WAIT_VS:   busy_s = 1'b0;
      default:               busy_s = 1'b0;
    endcase
  end

  // Column/row counters and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt_r   <= '0;
      row_cnt_r   <= '0;
      line_err_r  <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      if (start_s) begin
        col_cnt_r <= '0;
        row_cnt_r <= '0;
      end else if (line_end_s) begin
        col_cnt_r <= '0;
        row_cnt_r <= row_next_s;
      end else if (pix_s && (col_cnt_r != COL_END)) begin
        col_cnt_r <= col_cnt_r + CW'(1);
      end
      if (start_s)                                line_err_r <= 1'b0;
      else if (line_end_s && (col_cnt_r != COL_END)) line_err_r <= 1'b1;
      if (early_s || stray_s) frame_err_r <= 1'b1;
      else if (start_s)       frame_err_r <= 1'b0;
    end
  end

  // Registered window outputs and frame pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid_r   <= 1'b0;
      col_idx_r     <= '0;
      row_idx_r     <= '0;
      frame_start_r <= 1'b0;
      frame_done_r  <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      win_valid_r   <= win_s;
      frame_start_r <= start_s;
      frame_done_r  <= frame_done_s;
      busy_r        <= busy_s;
      if (pix_s) begin
        col_idx_r <= col_cnt_r;
        row_idx_r <= row_cnt_r;
      end
    end
  end

  assign win_valid   = win_valid_r;
  assign col_idx     = col_idx_r;
  assign row_idx     = row_idx_r;
  assign frame_start = frame_start_r;
  assign frame_done  = frame_done_r;
  assign line_err    = line_err_r;
  assign frame_err   = frame_err_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_matrix_window_ctrl.sv
// Scoreboard bench for matrix_window_ctrl with an 8x4 image.
module tb_matrix_window_ctrl;

  localparam int W = 8;
  localparam int H = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic        mat_vsync = 1'b1;
  logic        mat_href = 1'b0;
  logic        mat_clken = 1'b0;
  logic        win_valid;
  logic [10:0] col_idx;
  logic [9:0]  row_idx;
  logic        frame_start, frame_done, line_err, frame_err, busy;

  typedef struct {int cyc; int col; int row;} exp_t;
  exp_t exp_q[$];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int fs_cnt = 0;
  int fd_cnt = 0;
  int fd_cyc = 0;
  int win_cnt = 0;
  int last_fall_cyc = 0;
  int m_row = 0;
  int m_col = 0;
  bit m_in_frame = 1'b0;
  int win_base;

  matrix_window_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .mat_vsync(mat_vsync), .mat_href(mat_href), .mat_clken(mat_clken),
    .win_valid(win_valid), .col_idx(col_idx), .row_idx(row_idx),
    .frame_start(frame_start), .frame_done(frame_done),
    .line_err(line_err), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: count pulses and compare every presented window against the queue.
  always @(negedge clk) begin
    exp_t e;
    if (frame_start) fs_cnt++;
    if (frame_done) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
    if (win_valid) begin
      win_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL win_extra: got window col %0d row %0d, expected none (cycle %0d)",
                 col_idx, row_idx, cyc);
      end else begin
        e = exp_q.pop_front();
        check("win_cycle", cyc, e.cyc);
        check("win_col", int'(col_idx), e.col);
        check("win_row", int'(row_idx), e.row);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_pixel();
    if (m_in_frame) begin
      if (m_col >= 2 && m_row >= 2 && m_row < H) exp_q.push_back('{cyc + 1, m_col, m_row});
      if (m_col < W) m_col++;
    end
  endtask

  task automatic vsync_pulse(input bit accepted);
    mat_vsync = 1'b1;
    tick(); tick();
    mat_vsync = 1'b0;
    tick(); tick();
    if (accepted) begin
      m_in_frame = 1'b1;
      m_row = 0;
      m_col = 0;
    end
  endtask

  // One href line of npix clken samples, clken high one cycle in every period.
  task automatic drive_line(input int npix, input int period, input int drop_en_at);
    int k = 0;
    int sent = 0;
    mat_href = 1'b1;
    while (sent < npix) begin
      if (sent == drop_en_at) en = 1'b0;
      mat_clken = ((k % period) == 0);
      if (mat_clken) begin
        model_pixel();
        sent++;
      end
      k++;
      tick();
    end
    mat_clken = 1'b0;
    mat_href = 1'b0;
    last_fall_cyc = cyc;
    if (m_in_frame) begin
      m_col = 0;
      m_row++;
      if (m_row == H) m_in_frame = 1'b0;
    end
    repeat (4) tick();
  endtask

  task automatic check_outputs_zero();
    check("rst_win_valid", int'(win_valid), 0);
    check("rst_col_idx", int'(col_idx), 0);
    check("rst_row_idx", int'(row_idx), 0);
    check("rst_frame_start", int'(frame_start), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_line_err", int'(line_err), 0);
    check("rst_frame_err", int'(frame_err), 0);
    check("rst_busy", int'(busy), 0);
  endtask

  initial begin
    // Reset with vsync held high: must not start a frame afterwards.
    #12;
    check_outputs_zero();
    rst_n = 1'b1;
    repeat (4) tick();
    check("vs_through_reset_start", fs_cnt, 0);
    check("vs_through_reset_busy", int'(busy), 0);
    mat_vsync = 1'b0;
    repeat (3) tick();

    // Clean frame of 4 lines x 8 pixels.
    win_base = win_cnt;
    vsync_pulse(1'b1);
    check("clean_start", fs_cnt, 1);
    check("clean_busy", int'(busy), 1);
    repeat (4) drive_line(W, 1, -1);
    check("clean_done", fd_cnt, 1);
    check("clean_done_latency", fd_cyc, last_fall_cyc + 2);
    check("clean_win_count", win_cnt - win_base, 12);
    check("clean_line_err", int'(line_err), 0);
    check("clean_frame_err", int'(frame_err), 0);
    check("clean_idle_busy", int'(busy), 0);

    // Short line 1 sets a sticky line_err.
    vsync_pulse(1'b1);
    drive_line(W, 1, -1);
    check("short_before", int'(line_err), 0);
    drive_line(W - 1, 1, -1);
    check("short_set", int'(line_err), 1);
    drive_line(W, 1, -1);
    drive_line(W, 1, -1);
    check("short_sticky", int'(line_err), 1);
    check("short_done", fd_cnt, 2);

    // Next frame start clears line_err; vsync during line 2 aborts the frame.
    vsync_pulse(1'b1);
    check("clear_line_err", int'(line_err), 0);
    check("clear_start", fs_cnt, 3);
    drive_line(W, 1, -1);
    drive_line(W, 1, -1);
    mat_href = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mat_clken = 1'b1;
      model_pixel();
      tick();
    end
    mat_clken = 1'b0;
    mat_vsync = 1'b1;
    tick(); tick();
    mat_vsync = 1'b0;
    tick(); tick();
    check("early_frame_err", int'(frame_err), 1);
    check("early_start", fs_cnt, 4);
    mat_href = 1'b0;
    m_row = 0;
    m_col = 0;
    repeat (4) tick();
    drive_line(W, 1, -1);
    check("early_next_row", int'(row_idx), 0);
    check("early_next_col", int'(col_idx), W - 1);
    repeat (3) drive_line(W, 1, -1);
    check("early_done", fd_cnt, 3);
    check("early_frame_err_sticky", int'(frame_err), 1);

    // Gapped clken: one pixel every third cycle.
    vsync_pulse(1'b1);
    check("gap_frame_err_clear", int'(frame_err), 0);
    win_base = win_cnt;
    repeat (4) drive_line(W, 3, -1);
    check("gap_done", fd_cnt, 4);
    check("gap_win_count", win_cnt - win_base, 12);

    // Stray line after the last line, before any vsync.
    win_base = win_cnt;
    drive_line(W, 1, -1);
    check("stray_frame_err", int'(frame_err), 1);
    check("stray_no_window", win_cnt - win_base, 0);

    // en dropped during line 1: frame completes, next vsync ignored.
    vsync_pulse(1'b1);
    drive_line(W, 1, 3);
    repeat (3) drive_line(W, 1, -1);
    check("en_drop_done", fd_cnt, 5);
    vsync_pulse(1'b0);
    check("en_drop_no_start", fs_cnt, 6);
    check("en_drop_idle", int'(busy), 0);

    // Reset pulsed during line 3 (row index 2).
    en = 1'b1;
    repeat (2) tick();
    vsync_pulse(1'b1);
    drive_line(W, 1, -1);
    drive_line(W, 1, -1);
    mat_href = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mat_clken = 1'b1;
      model_pixel();
      tick();
    end
    mat_clken = 1'b0;
    tick(); tick();
    check("pre_reset_busy", int'(busy), 1);
    check("pre_reset_queue", exp_q.size(), 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero();
    mat_href = 1'b0;
    m_in_frame = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (6) tick();
    check("reset_no_done", fd_cnt, 5);

    // A clean frame after reset.
    win_base = win_cnt;
    vsync_pulse(1'b1);
    check("after_reset_start", fs_cnt, 8);
    repeat (4) drive_line(W, 1, -1);
    check("after_reset_done", fd_cnt, 6);
    check("after_reset_win_count", win_cnt - win_base, 12);
    check("after_reset_line_err", int'(line_err), 0);
    check("after_reset_frame_err", int'(frame_err), 0);
    check("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
